// File: rtl/spi_pkg.sv
// Shared SPI constants, receiver state encoding and a saturating-increment helper.
// Pure declarations: no latency, no backpressure.
package spi_pkg;

  localparam int SPI_BYTE_W      = 8;
  localparam int SPI_SYNC_STAGES = 2;
  localparam int SPI_BIT_CNT_W   = $clog2(SPI_BYTE_W);
  localparam int SPI_BYTE_CNT_W  = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_rx_state_t;

  function automatic logic [SPI_BYTE_CNT_W-1:0] spi_sat_inc(
    input logic [SPI_BYTE_CNT_W-1:0] val,
    input logic [SPI_BYTE_CNT_W-1:0] max_val
  );
    return (val >= max_val) ? val : val + 1'b1;
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// N-flop pin synchronizer whose flops reset to the pin's idle level (STAGES >= 2).
// Latency STAGES clk edges; no backpressure.
module spi_pin_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic n_rst,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync_q <= {STAGES{RST_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/spi_input_receiver.sv
// SPI mode-0 slave receiver: LSB-first shift-in, byte/frame boundary strobes, sticky abort flag.
// Latency SYNC_STAGES+1 clk from pin edge to strobe; no backpressure, every legal SCK edge is taken.
module spi_input_receiver
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = SPI_SYNC_STAGES,
  parameter int MAX_BYTES   = 255
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic                      SCK,
  input  logic                      SS,
  input  logic                      MOSI,
  output logic                      shift_SPI,
  output logic [SPI_BYTE_W-1:0]     SPI_in,
  output logic [SPI_BYTE_W-1:0]     rx_byte,
  output logic                      byte_valid,
  output logic                      frame_start,
  output logic [SPI_BYTE_CNT_W-1:0] byte_count,
  output logic                      frame_error
);

  localparam logic [SPI_BYTE_CNT_W-1:0] MAX_CNT = SPI_BYTE_CNT_W'(MAX_BYTES);

  logic sck_s, ss_s, mosi_s;

  spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
    .clk   (clk),
    .n_rst (n_rst),
    .d_i   (SCK),
    .q_o   (sck_s)
  );

  spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
    .clk   (clk),
    .n_rst (n_rst),
    .d_i   (SS),
    .q_o   (ss_s)
  );

  spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk   (clk),
    .n_rst (n_rst),
    .d_i   (MOSI),
    .q_o   (mosi_s)
  );

  logic                  sck_h_q, ss_h_q;
  logic [SYNC_STAGES:0]  flush_q;
  logic                  ss_armed_q;

  // The SS synchronizer resets to "high", so a pin already low at reset release
  // would look like a falling edge. Falls only count once SS has truly been seen high.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sck_h_q    <= 1'b0;
      ss_h_q     <= 1'b1;
      flush_q    <= '0;
      ss_armed_q <= 1'b0;
    end else begin
      sck_h_q    <= sck_s;
      ss_h_q     <= ss_s;
      flush_q    <= {flush_q[SYNC_STAGES-1:0], 1'b1};
      ss_armed_q <= ss_armed_q | (flush_q[SYNC_STAGES] & ss_s);
    end
  end

  logic sck_rise, ss_fall, ss_rise;

  assign sck_rise = sck_s & ~sck_h_q;
  assign ss_fall  = ss_armed_q & ss_h_q & ~ss_s;
  assign ss_rise  = ss_s & ~ss_h_q;

  spi_rx_state_t               state_q;
  logic [SPI_BIT_CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [SPI_BYTE_W-1:0]       spi_in_q, spi_in_d;
  logic [SPI_BYTE_W-1:0]       rx_byte_q;
  logic [SPI_BYTE_CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic                        shift_q, byte_valid_q, frame_start_q, frame_error_q;

  assign spi_in_d   = {mosi_s, spi_in_q[SPI_BYTE_W-1:1]};
  assign bit_cnt_d  = bit_cnt_q + 1'b1;
  assign byte_cnt_d = spi_sat_inc(byte_cnt_q, MAX_CNT);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= IDLE;
      bit_cnt_q     <= '0;
      spi_in_q      <= '0;
      rx_byte_q     <= '0;
      byte_cnt_q    <= '0;
      shift_q       <= 1'b0;
      byte_valid_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      shift_q       <= 1'b0;
      byte_valid_q  <= 1'b0;
      frame_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ss_fall) begin
            state_q       <= ACTIVE;
            frame_start_q <= 1'b1;
            byte_cnt_q    <= '0;
            frame_error_q <= 1'b0;
            // A coincident SCK rise becomes bit 0 of the new frame.
            if (sck_rise) begin
              spi_in_q  <= spi_in_d;
              shift_q   <= 1'b1;
              bit_cnt_q <= SPI_BIT_CNT_W'(1);
            end else begin
              bit_cnt_q <= '0;
            end
          end
        end
        ACTIVE: begin
          if (ss_rise) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            if (bit_cnt_q != '0) begin
              frame_error_q <= 1'b1;
            end
          end else if (sck_rise) begin
            spi_in_q  <= spi_in_d;
            shift_q   <= 1'b1;
            bit_cnt_q <= bit_cnt_d;
            if (bit_cnt_q == '1) begin
              rx_byte_q    <= spi_in_d;
              byte_valid_q <= 1'b1;
              byte_cnt_q   <= byte_cnt_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign shift_SPI   = shift_q;
  assign SPI_in      = spi_in_q;
  assign rx_byte     = rx_byte_q;
  assign byte_valid  = byte_valid_q;
  assign frame_start = frame_start_q;
  assign byte_count  = byte_cnt_q;
  assign frame_error = frame_error_q;

endmodule

// File: tb/tb_spi_input_receiver.sv
// Directed bench for spi_input_receiver: reset, single/multi-byte frames, abort, idle SCK, async reset.
`timescale 1ns/1ps
module tb_spi_input_receiver;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       SCK = 1'b0;
  logic       SS = 1'b1;
  logic       MOSI = 1'b0;
  logic       shift_SPI;
  logic [7:0] SPI_in;
  logic [7:0] rx_byte;
  logic       byte_valid;
  logic       frame_start;
  logic [7:0] byte_count;
  logic       frame_error;

  int n_checks = 0;
  int n_pass   = 0;
  int n_shift  = 0;
  int n_bv     = 0;
  int n_fs     = 0;

  spi_input_receiver dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .SCK         (SCK),
    .SS          (SS),
    .MOSI        (MOSI),
    .shift_SPI   (shift_SPI),
    .SPI_in      (SPI_in),
    .rx_byte     (rx_byte),
    .byte_valid  (byte_valid),
    .frame_start (frame_start),
    .byte_count  (byte_count),
    .frame_error (frame_error)
  );

  always #2.5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (shift_SPI === 1'b1) n_shift++;
    if (byte_valid === 1'b1) n_bv++;
    if (frame_start === 1'b1) n_fs++;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ss_low();
    @(negedge clk);
    SS = 1'b0;
    wait_clks(10);
  endtask

  task automatic ss_high();
    @(negedge clk);
    SS = 1'b1;
    wait_clks(10);
  endtask

  // One SCK period of ~16 clk; reports clk edges from SCK rise to strobe (-1 if none).
  task automatic send_bit(input logic b, output int lat, output logic bv);
    @(negedge clk);
    MOSI = b;
    wait_clks(8);
    SCK = 1'b1;
    lat = -1;
    bv  = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      #1;
      if (shift_SPI === 1'b1 && lat < 0) begin
        lat = i;
        bv  = byte_valid;
      end
    end
    @(negedge clk);
    SCK = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v, output int bad_lat, output int vcnt, output int vpos);
    int   lat;
    logic bv;
    bad_lat = 0;
    vcnt    = 0;
    vpos    = -1;
    for (int i = 0; i < 8; i++) begin
      send_bit(v[i], lat, bv);
      if (lat != 3) bad_lat++;
      if (bv === 1'b1) begin
        vcnt++;
        vpos = i;
      end
    end
    wait_clks(8);
  endtask

  task automatic test_reset();
    int s0, f0;
    n_rst = 1'b0;
    SS    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({shift_SPI, byte_valid, frame_start, frame_error} !== 4'b0)
      $display("FAIL reset_flags: got %b want 0000", {shift_SPI, byte_valid, frame_start, frame_error});
    else n_pass++;
    n_checks++;
    if ({SPI_in, rx_byte, byte_count} !== 24'h0)
      $display("FAIL reset_data: got %h want 000000", {SPI_in, rx_byte, byte_count});
    else n_pass++;
    @(negedge clk);
    n_rst = 1'b1;
    s0 = n_shift;
    f0 = n_fs;
    wait_clks(12);
    n_checks++;
    if (n_shift - s0 != 0 || n_fs - f0 != 0)
      $display("FAIL reset_no_strobe: got shift=%0d fs=%0d want 0 0", n_shift - s0, n_fs - f0);
    else n_pass++;
  endtask

  task automatic test_single_byte();
    int s0, f0, b0, bad, vc, vp;
    s0 = n_shift;
    f0 = n_fs;
    b0 = n_bv;
    ss_low();
    n_checks++;
    if (n_fs - f0 != 1) $display("FAIL single_frame_start: got %0d want 1", n_fs - f0);
    else n_pass++;
    send_byte(8'h85, bad, vc, vp);
    n_checks++;
    if (bad != 0) $display("FAIL single_latency: got %0d bad bits want 0", bad);
    else n_pass++;
    n_checks++;
    if (n_shift - s0 != 8) $display("FAIL single_strobes: got %0d want 8", n_shift - s0);
    else n_pass++;
    n_checks++;
    if (vc != 1 || vp != 7 || n_bv - b0 != 1)
      $display("FAIL single_byte_valid: got cnt=%0d pos=%0d total=%0d want 1 7 1", vc, vp, n_bv - b0);
    else n_pass++;
    n_checks++;
    if (rx_byte !== 8'h85) $display("FAIL single_rx_byte: got %h want 85", rx_byte);
    else n_pass++;
    n_checks++;
    if (SPI_in !== 8'h85) $display("FAIL single_spi_in: got %h want 85", SPI_in);
    else n_pass++;
    n_checks++;
    if (byte_count !== 8'd1) $display("FAIL single_byte_count: got %0d want 1", byte_count);
    else n_pass++;
    ss_high();
    n_checks++;
    if (frame_error !== 1'b0) $display("FAIL single_frame_error: got %b want 0", frame_error);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int b0, bad, vc, vp;
    b0 = n_bv;
    ss_low();
    send_byte(8'h01, bad, vc, vp);
    n_checks++;
    if (rx_byte !== 8'h01) $display("FAIL b2b_first_byte: got %h want 01", rx_byte);
    else n_pass++;
    send_byte(8'hFF, bad, vc, vp);
    n_checks++;
    if (n_bv - b0 != 2) $display("FAIL b2b_byte_valid: got %0d want 2", n_bv - b0);
    else n_pass++;
    n_checks++;
    if (rx_byte !== 8'hFF) $display("FAIL b2b_rx_byte: got %h want ff", rx_byte);
    else n_pass++;
    n_checks++;
    if (byte_count !== 8'd2) $display("FAIL b2b_byte_count: got %0d want 2", byte_count);
    else n_pass++;
    ss_high();
    n_checks++;
    if (frame_error !== 1'b0) $display("FAIL b2b_frame_error: got %b want 0", frame_error);
    else n_pass++;
  endtask

  task automatic test_abort();
    int   b0, f0, bad, vc, vp, lat;
    logic bv;
    ss_low();
    send_byte(8'hA5, bad, vc, vp);
    n_checks++;
    if (byte_count !== 8'd1) $display("FAIL abort_pre_count: got %0d want 1", byte_count);
    else n_pass++;
    b0 = n_bv;
    for (int i = 0; i < 5; i++) send_bit(1'b1, lat, bv);
    ss_high();
    n_checks++;
    if (frame_error !== 1'b1) $display("FAIL abort_frame_error: got %b want 1", frame_error);
    else n_pass++;
    n_checks++;
    if (n_bv - b0 != 0 || rx_byte !== 8'hA5)
      $display("FAIL abort_no_byte: got bv=%0d rx=%h want 0 a5", n_bv - b0, rx_byte);
    else n_pass++;
    f0 = n_fs;
    ss_low();
    n_checks++;
    if (n_fs - f0 != 1) $display("FAIL abort_frame_start: got %0d want 1", n_fs - f0);
    else n_pass++;
    n_checks++;
    if (frame_error !== 1'b0 || byte_count !== 8'd0)
      $display("FAIL abort_cleared: got err=%b cnt=%0d want 0 0", frame_error, byte_count);
    else n_pass++;
    ss_high();
    n_checks++;
    if (frame_error !== 1'b0) $display("FAIL abort_empty_frame: got %b want 0", frame_error);
    else n_pass++;
  endtask

  task automatic test_idle_sck();
    int         s0, lat;
    logic       bv;
    logic [7:0] snap;
    snap = SPI_in;
    s0   = n_shift;
    for (int i = 0; i < 4; i++) send_bit(i[0], lat, bv);
    wait_clks(8);
    n_checks++;
    if (n_shift - s0 != 0) $display("FAIL idle_strobes: got %0d want 0", n_shift - s0);
    else n_pass++;
    n_checks++;
    if (SPI_in !== snap) $display("FAIL idle_spi_in: got %h want %h", SPI_in, snap);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    int   s0, f0, lat, bad, vc, vp;
    logic bv;
    ss_low();
    for (int i = 0; i < 3; i++) send_bit(1'b1, lat, bv);
    wait_clks(4);
    n_checks++;
    if (SPI_in[7:5] !== 3'b111) $display("FAIL arst_pre_bits: got %b want 111", SPI_in[7:5]);
    else n_pass++;
    @(negedge clk);
    #1;
    n_rst = 1'b0;
    #1;
    n_checks++;
    if ({SPI_in, rx_byte, byte_count, shift_SPI, byte_valid, frame_start, frame_error} !== 28'h0)
      $display("FAIL arst_immediate: got %h want 0000000",
               {SPI_in, rx_byte, byte_count, shift_SPI, byte_valid, frame_start, frame_error});
    else n_pass++;
    wait_clks(2);
    n_rst = 1'b1;
    s0 = n_shift;
    f0 = n_fs;
    wait_clks(12);
    send_byte(8'h3C, bad, vc, vp);
    n_checks++;
    if (n_shift - s0 != 0 || n_fs - f0 != 0 || byte_count !== 8'd0)
      $display("FAIL arst_ignored: got shift=%0d fs=%0d cnt=%0d want 0 0 0", n_shift - s0, n_fs - f0, byte_count);
    else n_pass++;
    ss_high();
    ss_low();
    n_checks++;
    if (n_fs - f0 != 1) $display("FAIL arst_reframe: got %0d want 1", n_fs - f0);
    else n_pass++;
    send_byte(8'h3C, bad, vc, vp);
    n_checks++;
    if (rx_byte !== 8'h3C || byte_count !== 8'd1)
      $display("FAIL arst_after_byte: got rx=%h cnt=%0d want 3c 1", rx_byte, byte_count);
    else n_pass++;
    ss_high();
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_abort();
    test_idle_sck();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/spi_input_receiver.md
# spi_input_receiver

Front-end SPI slave receiver for the digit recognizer. Samples the host's SCK/SS/MOSI pins in the `clk` domain and shifts MOSI bits in LSB-first. Drives the `shift_SPI` strobe and `SPI_in` byte that `SPI_output_controller` consumes, and reports byte and frame boundaries to the command/data path. It sits directly upstream of `SPI_output_controller`, and both share the same SCK/SS pins.

## Interface
- `SYNC_STAGES`, 2, synchronizer depth for SCK, SS and MOSI (minimum 2).
- `MAX_BYTES`, 255, byte-count saturation value.
- `clk` in 1: system clock, 200 MHz.
- `n_rst` in 1: reset, asynchronous, active-low.
- `SCK` in 1: SPI clock, mode 0; MOSI is sampled on SCK rising.
- `SS` in 1: slave select, active-low.
- `MOSI` in 1: serial data in.
- `shift_SPI` out 1: one-cycle strobe, one per accepted SCK rising edge.
- `SPI_in` out 8: receive shift register, live contents.
- `rx_byte` out 8: last complete byte, held until the next complete byte.
- `byte_valid` out 1: one-cycle pulse when `rx_byte` updates.
- `frame_start` out 1: one-cycle pulse on a synchronized SS falling edge.
- `byte_count` out 8: complete bytes in the current frame, saturating at `MAX_BYTES`.
- `frame_error` out 1: sticky flag; set when SS rises mid-byte, cleared on the next `frame_start`.

## Operation
- **Synchronization.** SCK, SS and MOSI each pass through `SYNC_STAGES` flops, followed by one history flop for SCK and SS edge detection. All three paths have equal depth, so MOSI is aligned with its SCK edge.
- **States:** IDLE, ACTIVE.
  - IDLE → ACTIVE on a synchronized SS falling edge. On that transition: pulse `frame_start`, clear the bit counter, `byte_count` and `frame_error`.
  - ACTIVE → IDLE on a synchronized SS rising edge. If the bit counter ≠ 0, set `frame_error` and discard the partial byte. `SPI_in` keeps its value.
- **Per-bit behaviour in ACTIVE, on each synchronized SCK rising edge:**
  - `SPI_in <= {MOSI_s, SPI_in[7:1]}` (LSB-first, matching the output controller's MISO order).
  - Pulse `shift_SPI`.
  - Increment the 3-bit bit counter.
- **Byte completion (bit counter wraps 7→0):**
  - `rx_byte <= {MOSI_s, SPI_in[7:1]}`.
  - Pulse `byte_valid` in the same cycle as that bit's `shift_SPI`.
  - Increment `byte_count`, saturating at `MAX_BYTES`.
- SCK edges in IDLE are ignored: no strobe, no shift.
- SCK falling edges are ignored; MISO timing is owned downstream.
- SS falling and SCK rising in the same synchronized cycle: `frame_start` takes effect first, and the SCK edge is accepted as bit 0 of the new frame.
- SS rising and SCK rising in the same synchronized cycle: the SCK edge is dropped.

## Timing
- **Reset values:**
  - State = IDLE.
  - `SPI_in` = 0, `rx_byte` = 0, `byte_count` = 0.
  - `shift_SPI`, `byte_valid`, `frame_start`, `frame_error` = 0.
  - All synchronizer flops reset to their idle pin levels: SCK = 0, SS = 1, MOSI = 0.
- **Latency.** Pin edge to strobe is `SYNC_STAGES`+1 clk rising edges (3 at default), measured from the first clk edge that samples the new pin level. `shift_SPI`, `SPI_in` and `byte_valid` change on the same clk edge.
- **Pulse width.** Every strobe is exactly 1 clk wide, and all outputs are registered.
- **Legal SCK.** High and low phases must each last at least `SYNC_STAGES`+1 clk periods (the 83 ns SCK is roughly 16 clk periods). Narrower pulses are out of spec; behaviour is undefined, but the block must not hang.
- **Setup.** MOSI must be stable for at least 1 clk period before SCK rises.
- **Reset mid-frame.** Asynchronous assertion clears everything immediately. After release the block stays in IDLE until the next SS falling edge is seen, even if SS is already low.

## Structure
- **Package `spi_pkg`:**
  - `SPI_BYTE_W = 8`.
  - Default `SYNC_STAGES`.
  - State enum `spi_rx_state_t {IDLE, ACTIVE}`.
  - Bit-counter width `$clog2(SPI_BYTE_W)`.
  - `SPI_output_controller` imports `SPI_BYTE_W` from the same package.
- **Sub-module `spi_pin_sync`.** Parameterized N-stage synchronizer with a reset-value parameter, instantiated three times.
- **Top.** FSM, shift register, bit/byte counters and output registers live in the top.

## Test plan
1. **Reset.** `n_rst` low for 2 clk with SS=1 → all outputs 0, and no strobe after release.
2. **Single byte.** SS low, send 8'h85 LSB-first at 83 ns SCK:
   - 8 `shift_SPI` pulses, each 3 clk after its SCK rise.
   - `byte_valid` coincides with the 8th strobe.
   - `rx_byte` = 8'h85, `byte_count` = 1.
3. **Two-byte frame.** 8'h01 then 8'hFF → `byte_valid` twice, final `rx_byte` = 8'hFF, `byte_count` = 2, `frame_error` = 0.
4. **Aborted byte.** SS rises after 5 bits → `frame_error` = 1, no `byte_valid`. The next SS fall gives a `frame_start` pulse and clears `frame_error` and `byte_count`.
5. **Idle SCK.** SCK toggling with SS high → zero `shift_SPI` pulses and `SPI_in` unchanged.
6. **Async reset mid-byte.** `n_rst` low after 3 bits → outputs clear within the same clk period. After release with SS held low, SCK edges are ignored until SS toggles high then low.
